data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-requester arbiter that shares the single-port `data_memory` between the processor (requester 0) and a secondary bus master (requester 1, e.g. a program loader or display reader). It sits between the requesters and the data memory. It accepts one transaction at a time, round-robin, with a request/grant/response handshake. It registers the address, write enable and write data, drives them to memory for one cycle, and returns the captured read data one cycle later.

## Interface
- `ADDR_W`, default 32: address width of requesters and memory.
- `DATA_W`, default 32: data width.

- `clk_i` input 1: single clock; all state changes on its rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `req_i` input 2: per-requester request; bit k for requester k.
- `we_i` input 2: per-requester write enable; 1 = write, 0 = read.
- `addr0_i` input ADDR_W: requester 0 address.
- `addr1_i` input ADDR_W: requester 1 address.
- `wdata0_i` input DATA_W: requester 0 write data.
- `wdata1_i` input DATA_W: requester 1 write data.
- `gnt_o` output 2: one-hot grant; combinational.
- `rvalid_o` output 2: one-hot response valid; registered.
- `rdata_o` output DATA_W: read data for the requester flagged by `rvalid_o`; shared by both requesters.
- `busy_o` output 1: high when state is not IDLE.
- `mem_write_o` output 1: data memory write enable.
- `mem_address_o` output ADDR_W: data memory address.
- `mem_write_data_o` output DATA_W: data memory write data.
- `mem_read_data_i` input DATA_W: data memory combinational read data.

## Operation
- State machine has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Priority pointer `prio` is 1 bit; reset value 0.
- **IDLE**
  - If exactly one `req_i` bit is set, that requester wins.
  - If both bits are set, requester `prio` wins.
  - `gnt_o[winner]` = 1 in the same cycle.
  - At the clock edge the block latches `addr`, `we` and `wdata` of the winner plus the winner index, then goes to ACCESS.
  - With no request, `gnt_o` = 0 and the block stays in IDLE.
- **ACCESS**
  - `mem_address_o` and `mem_write_data_o` come from the latched registers.
  - `mem_write_o` = latched `we`. A write commits at the edge ending ACCESS.
  - `mem_read_data_i` is captured into the `rdata` register at that edge, for reads and writes alike.
  - Next state is RESP.
- **RESP**
  - `rvalid_o[winner]` = 1 for exactly one cycle.
  - `rdata_o` holds the captured data. For writes it holds the memory's read of the written address.
  - `prio` becomes ~winner at the edge ending RESP. Next state is IDLE.
- `gnt_o` is 0 in ACCESS and RESP. Requests are not accepted there.
- Arbitration rules:
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - After `gnt` it may drop `req`.
  - A `req` still high in the cycle after RESP counts as a new request.
- Round-robin guarantee: a requester with continuous `req` is served within 2 transactions.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Output reset values:
  - `gnt_o`=0, `rvalid_o`=0, `busy_o`=0, `mem_write_o`=0.
  - `mem_address_o`=0, `mem_write_data_o`=0, `rdata_o`=0.
- Outside ACCESS, `mem_address_o` and `mem_write_data_o` hold their last latched values. `mem_write_o` is 0.
- Reset asserted mid-transaction:
  - The block immediately returns to IDLE, `mem_write_o` drops to 0 and `rvalid_o` drops to 0.
  - An in-flight transaction is abandoned; a write that has not reached its ACCESS edge does not commit.
  - The requester must reissue.

## Timing
- Transaction latency: grant in cycle T (IDLE), memory access in T+1, `rvalid` in T+2. Earliest next grant is T+3.
- Peak throughput is one transaction per 3 cycles.
- `gnt_o` is a combinational function of `req_i`, state and `prio`. All other outputs are registered.
- A requester-side read value is valid only while its `rvalid_o` bit is high.
- Simultaneous requests in IDLE: only one grant; the loser keeps requesting.

## Test plan
- **Reset values:** hold `rst_i`=0 with random inputs → every output 0. Release → IDLE, `busy_o`=0.
- **Single write then read, requester 0:**
  - Write `addr0_i`=0x40, `wdata0_i`=0xDEADBEEF → `gnt_o`=01 at T; at T+1 `mem_write_o`=1, `mem_address_o`=0x40; `rvalid_o`=01 at T+2.
  - Then read 0x40 → `rdata_o`=0xDEADBEEF with `rvalid_o`=01.
- **Contention after reset:**
  - Both requesters read continuously (0x10 and 0x20) → grants alternate 01, 10, 01, 10.
  - Grants are spaced 3 cycles apart.
  - `mem_address_o` alternates 0x10 and 0x20.
- **Single requester:** requester 1 alone requests back-to-back with `prio`=0 → served every 3 cycles with no idle gap and no grant to requester 0.
- **Reset during ACCESS:**
  - Requester 1 writes 0x55 to 0x80; `rst_i`=0 asserted mid-ACCESS before the edge → `mem_write_o` falls immediately and no `rvalid`.
  - After release, requester 0 reads 0x80 → prior contents, not 0x55.
- **Request during busy:** raise `req_i[1]` during ACCESS of a requester-0 transaction → no `gnt_o` until the following IDLE cycle, then `gnt_o`=10.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the processor (0)
// and a secondary bus master (1). One transaction every three cycles: IDLE, ACCESS, RESP.
module data_memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              prio_q;
    logic              win_q;
    logic              we_q;
    logic              busy_q;
    logic [1:0]        rvalid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              win_d;
    logic [1:0]        gnt_d;

    // Grant is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        win_d = (req_i == 2'b11) ? prio_q : req_i[1];
        gnt_d = 2'b00;
        if (rst_i && state_q == IDLE && req_i != 2'b00)
            gnt_d = win_d ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_d != 2'b00) begin
                        win_q   <= win_d;
                        we_q    <= we_i[win_d];
                        addr_q  <= win_d ? addr1_i : addr0_i;
                        wdata_q <= win_d ? wdata1_i : wdata0_i;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Captured for writes too: requester sees the memory's read of that address.
                    rdata_q  <= mem_read_data_i;
                    we_q     <= 1'b0;
                    rvalid_q <= win_q ? 2'b10 : 2'b01;
                    state_q  <= RESP;
                end
                RESP: begin
                    rvalid_q <= 2'b00;
                    prio_q   <= ~win_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o            = gnt_d;
    assign rvalid_o         = rvalid_q;
    assign rdata_o          = rdata_q;
    assign busy_o           = busy_q;
    assign mem_write_o      = we_q;
    assign mem_address_o    = addr_q;
    assign mem_write_data_o = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model with its own shadow of the data memory.
module tb_data_memory_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = '0, we = '0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mrd, mwd;
    logic          busy, mw;
    logic [AW-1:0] ma;

    logic [DW-1:0] tb_mem [256];
    logic [DW-1:0] ref_mem [256];

    int n_tests = 0, n_fail = 0, cyc = 0;

    // model of the arbiter at transaction level
    int            m_phase;
    bit            m_prio, m_win, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    logic [1:0] last_gnt = '0, pend = '0;
    logic [1:0] gq[$];
    int         gc[$];

    always #5 clk = ~clk;

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we),
        .addr0_i(a0), .addr1_i(a1), .wdata0_i(d0), .wdata1_i(d1),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
        .mem_write_o(mw), .mem_address_o(ma), .mem_write_data_o(mwd),
        .mem_read_data_i(mrd)
    );

    always @(posedge clk) if (mw) tb_mem[ma[7:0]] <= mwd;
    assign mrd = tb_mem[ma[7:0]];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_phase = 0; m_prio = 0; m_win = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic [1:0] eg;
        bit w;
        @(negedge clk);
        eg = 2'b00;
        w  = 0;
        if (m_phase == 0 && req != 2'b00) begin
            w  = (req == 2'b11) ? m_prio : req[1];
            eg = w ? 2'b10 : 2'b01;
        end
        chk("gnt", 64'(gnt), 64'(eg));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("mem_write", 64'(mw), 64'((m_phase == 1) ? m_we : 1'b0));
        chk("rvalid", 64'(rvalid), 64'((m_phase == 2) ? (m_win ? 2'b10 : 2'b01) : 2'b00));
        chk("mem_addr", 64'(ma), 64'(m_addr));
        chk("mem_wdata", 64'(mwd), 64'(m_wdata));
        if (m_phase == 2) chk("rdata", 64'(rdata), 64'(m_rdata));
        if (gnt != 2'b00) begin gq.push_back(gnt); gc.push_back(cyc); end
        last_gnt = gnt;
        case (m_phase)
            0: if (eg != 2'b00) begin
                m_win = w; m_we = we[w];
                m_addr = w ? a1 : a0; m_wdata = w ? d1 : d0;
                m_phase = 1;
            end
            1: begin
                m_rdata = ref_mem[m_addr[7:0]];
                if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                m_phase = 2;
            end
            default: begin m_prio = ~m_win; m_phase = 0; end
        endcase
        cyc++;
        @(posedge clk); #1;
    endtask

    // Requesters follow the protocol: hold until granted, then maybe issue a fresh request.
    task automatic drive_random(int pct);
        for (int k = 0; k < 2; k++) begin
            if (!pend[k] || last_gnt[k]) begin
                pend[k] = ($urandom_range(99) < pct);
                we[k]   = $urandom_range(1);
                if (k == 0) begin a0 = 32'($urandom_range(255)); d0 = $urandom; end
                else        begin a1 = 32'($urandom_range(255)); d1 = $urandom; end
            end
        end
        req = pend;
    endtask

    task automatic pulse_reset();
        rst_n = 0; #3;
        reset_model();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        reset_model();

        // Reset held with random inputs: every output 0
        for (int i = 0; i < 3; i++) begin
            req = 2'($urandom); we = 2'($urandom);
            a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
            @(negedge clk);
            chk("rst_outputs", {gnt, rvalid, busy, mw}, 64'd0);
            chk("rst_mem_addr", 64'(ma), 64'd0);
            chk("rst_mem_wdata", 64'(mwd), 64'd0);
            chk("rst_rdata", 64'(rdata), 64'd0);
        end
        req = 0; we = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        cycle();

        // Requester 0 write then read of 0x40
        req = 2'b01; we = 2'b01; a0 = 32'h40; d0 = 32'hDEADBEEF;
        cycle();
        req = 2'b00;
        chk("wr_mem_write", 64'(mw), 64'd1);
        chk("wr_mem_addr", 64'(ma), 64'h40);
        cycle();
        chk("wr_rvalid", 64'(rvalid), 64'b01);
        cycle();
        req = 2'b01; we = 2'b00;
        cycle();
        req = 2'b00;
        cycle();
        chk("rd40_rvalid", 64'(rvalid), 64'b01);
        chk("rd40_rdata", 64'(rdata), 64'hDEADBEEF);
        cycle();

        // Contention right after reset: alternate 01,10,01,10 three cycles apart
        pulse_reset();
        req = 2'b11; we = 2'b00; a0 = 32'h10; a1 = 32'h20;
        gq.delete(); gc.delete();
        for (int i = 0; i < 12; i++) cycle();
        chk("cont_ngrants", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            chk("cont_order", 64'(gq[i]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            if (i > 0) chk("cont_spacing", 64'(gc[i] - gc[i-1]), 64'd3);
        end

        // Requester 1 alone, back to back with prio at 0
        req = 2'b10;
        gq.delete(); gc.delete();
        for (int i = 0; i < 9; i++) cycle();
        chk("single_ngrants", 64'(gq.size()), 64'd3);
        for (int i = 0; i < gq.size(); i++) begin
            chk("single_gnt", 64'(gq[i]), 64'b10);
            if (i > 0) chk("single_spacing", 64'(gc[i] - gc[i-1]), 64'd3);
        end
        req = 2'b00;
        cycle(); cycle();

        // Reset in the middle of an ACCESS write: no commit, no response
        req = 2'b10; we = 2'b10; a1 = 32'h80; d1 = 32'h55;
        cycle();
        req = 2'b00; we = 2'b00;
        chk("mid_mem_write_pre", 64'(mw), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("mid_mem_write", 64'(mw), 64'd0);
        chk("mid_rvalid", 64'(rvalid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        reset_model();
        @(posedge clk); #1;
        rst_n = 1;
        req = 2'b01; a0 = 32'h80;
        cycle();
        req = 2'b00;
        cycle();
        chk("mid_rd80", 64'(rdata), 64'hC0DE0080);
        cycle();

        // Request raised during a requester-0 ACCESS waits for the next IDLE
        gq.delete(); gc.delete();
        req = 2'b01; a0 = 32'h08;
        cycle();
        req = 2'b10; a1 = 32'h0C;
        cycle(); cycle(); cycle();
        req = 2'b00;
        cycle(); cycle();
        chk("busy_ngrants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            chk("busy_gnt1", 64'(gq[1]), 64'b10);
            chk("busy_spacing", 64'(gc[1] - gc[0]), 64'd3);
        end

        // Random traffic
        pend = '0; last_gnt = '0;
        for (int i = 0; i < 400; i++) begin
            drive_random(60);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
